acc_src_sel: RTL

ACC_SRC_SEL -- requirements
Module: acc_src_sel

---
 rtl/acc_src_sel_pkg.sv | 34 +++
 rtl/acc_src_sel_timer.sv | 38 +++
 rtl/acc_src_sel.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/acc_src_sel_pkg.sv
// Shared definitions for the accumulator source select block.
// Holds the source codes, FSM state encoding, error codes and parameter defaults.
package acc_src_sel_pkg;

  // Accumulator-select source codes used by the pipeline decoder
  localparam logic [2:0] ACC_SRC_IMM   = 3'd0;
  localparam logic [2:0] ACC_SRC_ALU   = 3'd1;
  localparam logic [2:0] ACC_SRC_ADC0  = 3'd2;
  localparam logic [2:0] ACC_SRC_ADC1  = 3'd3;
  localparam logic [2:0] ACC_SRC_PLL   = 3'd4;
  localparam logic [2:0] ACC_SRC_LDO   = 3'd5;
  localparam logic [2:0] ACC_SRC_GPIO  = 3'd6;
  localparam logic [2:0] ACC_SRC_SPARE = 3'd7;

  localparam int          DEF_DATA_W       = 8;
  localparam int          DEF_NUM_SRC      = 8;
  localparam int          DEF_SEL_W        = 3;
  localparam logic [15:0] DEF_ALWAYS_VALID = 16'b0000_0000_0000_0011;
  localparam int          DEF_TIMEOUT      = 15;

  localparam int TMR_CNT_W = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } acc_state_e;

  typedef enum logic [1:0] {
    ERR_NONE        = 2'b00,
    ERR_ILLEGAL_SEL = 2'b01,
    ERR_TIMEOUT     = 2'b10
  } acc_err_e;

endpackage

// File: rtl/acc_src_sel_timer.sv
// Wait-cycle counter for the source select FSM.
// Synchronous clear beats increment; terminal flag marks the last allowed WAIT cycle.
module acc_src_sel_timer
  import acc_src_sel_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clr_i,
  input  logic                 inc_i,
  output logic [TMR_CNT_W-1:0] cnt_o,
  output logic                 tc_o
);

  logic [TMR_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + TMR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == TMR_CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/acc_src_sel.sv
// Accumulator source select: loads one of NUM_SRC source words into a registered
// accumulator, stalling in WAIT for slow sources with a bounded timeout.
//   state   | meaning
//   IDLE    | accept req; immediate load, illegal-select error, or go to WAIT
//   WAIT    | stalled on sel_q until its valid arrives or the timer expires
module acc_src_sel
  import acc_src_sel_pkg::*;
#(
  parameter int                   DATA_W       = DEF_DATA_W,
  parameter int                   NUM_SRC      = DEF_NUM_SRC,
  parameter int                   SEL_W        = DEF_SEL_W,
  parameter logic [NUM_SRC-1:0]   ALWAYS_VALID = NUM_SRC'(DEF_ALWAYS_VALID),
  parameter int                   TIMEOUT      = DEF_TIMEOUT
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        req_i,
  input  logic [SEL_W-1:0]            sel_i,
  input  logic [NUM_SRC*DATA_W-1:0]   src_data_i,
  input  logic [NUM_SRC-1:0]          src_valid_i,
  output logic [NUM_SRC-1:0]          src_rd_o,
  output logic [DATA_W-1:0]           acc_data_o,
  output logic                        acc_valid_o,
  output logic                        busy_o,
  output logic                        err_o,
  output logic [1:0]                  err_code_o
);

  localparam int CH_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int BASE_W = $clog2(NUM_SRC * DATA_W);

  if (NUM_SRC < 2 || NUM_SRC > 16) begin : g_bad_num_src
    $error("acc_src_sel: NUM_SRC out of range 2..16");
  end
  if ((2 ** SEL_W) < NUM_SRC) begin : g_bad_sel_w
    $error("acc_src_sel: SEL_W too narrow for NUM_SRC");
  end
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("acc_src_sel: TIMEOUT out of range 1..255");
  end

  acc_state_e          state_q, state_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [DATA_W-1:0]   acc_data_q, acc_data_d;
  logic                acc_valid_q, acc_valid_d;
  logic [NUM_SRC-1:0]  src_rd_q, src_rd_d;
  logic                err_q, err_d;
  logic [1:0]          err_code_q, err_code_d;

  logic                 tmr_clr, tmr_inc, tmr_tc;
  logic [TMR_CNT_W-1:0] tmr_cnt;

  logic                 sel_legal;
  logic [SEL_W-1:0]     act_sel;
  logic [CH_W-1:0]      ch_idx;
  logic [BASE_W-1:0]    ch_base;
  logic [DATA_W-1:0]    ch_data;
  logic                 ch_valid;
  logic                 ch_always;
  logic [NUM_SRC-1:0]   ch_onehot;

  acc_src_sel_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (tmr_clr),
    .inc_i  (tmr_inc),
    .cnt_o  (tmr_cnt),
    .tc_o   (tmr_tc)
  );

  // In WAIT the latched select drives the mux; an illegal IDLE select is
  // steered to channel 0 so the part-select never leaves the source bus.
  assign sel_legal = (int'(sel_i) < NUM_SRC);
  assign act_sel   = (state_q == ST_WAIT) ? sel_q : sel_i;
  assign ch_idx    = ((state_q == ST_WAIT) || sel_legal) ? CH_W'(act_sel) : '0;
  assign ch_base   = BASE_W'(ch_idx) * BASE_W'(DATA_W);
  assign ch_data   = src_data_i[ch_base +: DATA_W];
  assign ch_valid  = src_valid_i[ch_idx];
  assign ch_always = ALWAYS_VALID[ch_idx];
  assign ch_onehot = ch_always ? '0 : (NUM_SRC'(1) << ch_idx);

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    acc_data_d  = acc_data_q;
    acc_valid_d = 1'b0;
    src_rd_d    = '0;
    err_d       = 1'b0;
    err_code_d  = err_code_q;
    tmr_clr     = 1'b0;
    tmr_inc     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_i) begin
          if (!sel_legal) begin
            err_d      = 1'b1;
            err_code_d = ERR_ILLEGAL_SEL;
          end else if (ch_always || ch_valid) begin
            acc_data_d  = ch_data;
            acc_valid_d = 1'b1;
            src_rd_d    = ch_onehot;
          end else begin
            sel_d   = sel_i;
            tmr_clr = 1'b1;
            state_d = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        // Valid is checked before the terminal count so a late arrival still loads
        if (ch_valid) begin
          acc_data_d  = ch_data;
          acc_valid_d = 1'b1;
          src_rd_d    = ch_onehot;
          state_d     = ST_IDLE;
        end else if (tmr_tc) begin
          err_d      = 1'b1;
          err_code_d = ERR_TIMEOUT;
          state_d    = ST_IDLE;
        end else begin
          tmr_inc = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      sel_q       <= '0;
      acc_data_q  <= '0;
      acc_valid_q <= 1'b0;
      src_rd_q    <= '0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      acc_data_q  <= acc_data_d;
      acc_valid_q <= acc_valid_d;
      src_rd_q    <= src_rd_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
    end
  end

  assign src_rd_o    = src_rd_q;
  assign acc_data_o  = acc_data_q;
  assign acc_valid_o = acc_valid_q;
  assign busy_o      = (state_q == ST_WAIT);
  assign err_o       = err_q;
  assign err_code_o  = err_code_q;

endmodule
